// File: rtl/arm_pkg.sv
// Shared ARM execute-stage encodings.
// EXE_CMD values, shift types, forwarding selects and SR bit positions.
package arm_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_e;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

endpackage

// File: rtl/exe_module_val2_generator.sv
// Second-operand generator: rotated immediate, memory offset or shifted Rm.
// Ports: imm, mem_en, shift_operand[11:0], op2 in; val2 out. Purely combinational.
module val2_generator
  import arm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             imm,
  input  logic             mem_en,
  input  logic [11:0]      shift_operand,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] val2
);

  logic [WIDTH-1:0]   imm_ext;
  logic [4:0]         rot_amt;
  logic [4:0]         sh_amt;
  logic [1:0]         sh_type;
  logic [2*WIDTH-1:0] dbl;

  assign imm_ext = WIDTH'(shift_operand[7:0]);
  assign rot_amt = {shift_operand[11:8], 1'b0};
  assign sh_amt  = shift_operand[11:7];
  assign sh_type = shift_operand[6:5];

  // Rotates are done by shifting a doubled copy right.
  always_comb begin
    dbl  = '0;
    val2 = op2;
    if (imm) begin
      dbl  = {imm_ext, imm_ext} >> rot_amt;
      val2 = dbl[WIDTH-1:0];
    end else if (mem_en) begin
      val2 = WIDTH'(shift_operand);
    end else begin
      case (sh_type)
        SH_LSL:  val2 = op2 << sh_amt;
        SH_LSR:  val2 = op2 >> sh_amt;
        SH_ASR:  val2 = $unsigned($signed(op2) >>> sh_amt);
        default: begin
          dbl  = {op2, op2} >> sh_amt;
          val2 = dbl[WIDTH-1:0];
        end
      endcase
    end
  end

endmodule

// File: rtl/exe_module.sv
// ARM execute stage: forwarding, Val2, ALU, NZCV register, branch target, EXE/MEM reg.
// Ports: ID/EXE controls and operands in; SR, branch outputs, registered EXE/MEM fields out.
module exe_module
  import arm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             WB_EN_IN,
  input  logic             MEM_R_EN_IN,
  input  logic             MEM_W_EN_IN,
  input  logic             B_IN,
  input  logic             S_IN,
  input  logic [3:0]       EXE_CMD,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] Val_Rn,
  input  logic [WIDTH-1:0] Val_Rm,
  input  logic             imm,
  input  logic [11:0]      Shift_operand,
  input  logic [23:0]      Signed_imm_24,
  input  logic [3:0]       Dest_IN,
  input  logic [1:0]       Sel_src1,
  input  logic [1:0]       Sel_src2,
  input  logic [WIDTH-1:0] MEM_ALU_Result,
  input  logic [WIDTH-1:0] WB_Value,
  output logic [3:0]       SR,
  output logic             Branch_Taken,
  output logic [WIDTH-1:0] Branch_Address,
  output logic             WB_EN,
  output logic             MEM_R_EN,
  output logic             MEM_W_EN,
  output logic [WIDTH-1:0] ALU_Result,
  output logic [WIDTH-1:0] ST_Val,
  output logic [3:0]       Dest
);

  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] val2;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   sum;
  logic [3:0]       flags_nxt;
  logic [3:0]       sr_q;
  logic             cin;
  logic             cmd_ok;

  always_comb begin
    case (Sel_src1)
      FWD_MEM: op1 = MEM_ALU_Result;
      FWD_WB:  op1 = WB_Value;
      default: op1 = Val_Rn;
    endcase
  end

  always_comb begin
    case (Sel_src2)
      FWD_MEM: op2 = MEM_ALU_Result;
      FWD_WB:  op2 = WB_Value;
      default: op2 = Val_Rm;
    endcase
  end

  val2_generator #(.WIDTH(WIDTH)) u_val2 (
    .imm           (imm),
    .mem_en        (MEM_R_EN_IN | MEM_W_EN_IN),
    .shift_operand (Shift_operand),
    .op2           (op2),
    .val2          (val2)
  );

  assign cin = sr_q[SR_C];

  // C/V default to the old SR so logical ops keep them.
  always_comb begin
    alu_res   = '0;
    sum       = '0;
    cmd_ok    = 1'b1;
    flags_nxt = sr_q;
    case (EXE_CMD)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_AND: alu_res = op1 & val2;
      CMD_ORR: alu_res = op1 | val2;
      CMD_EOR: alu_res = op1 ^ val2;
      CMD_ADD, CMD_ADC: begin
        sum = {1'b0, op1} + {1'b0, val2}
            + {{WIDTH{1'b0}}, (EXE_CMD == CMD_ADC) & cin};
        alu_res         = sum[WIDTH-1:0];
        flags_nxt[SR_C] = sum[WIDTH];
        flags_nxt[SR_V] = (op1[WIDTH-1] == val2[WIDTH-1])
                        & (alu_res[WIDTH-1] != op1[WIDTH-1]);
      end
      CMD_SUB, CMD_SBC: begin
        sum = {1'b0, op1} - {1'b0, val2}
            - {{WIDTH{1'b0}}, (EXE_CMD == CMD_SBC) & ~cin};
        alu_res         = sum[WIDTH-1:0];
        flags_nxt[SR_C] = ~sum[WIDTH];
        flags_nxt[SR_V] = (op1[WIDTH-1] != val2[WIDTH-1])
                        & (alu_res[WIDTH-1] != op1[WIDTH-1]);
      end
      default: cmd_ok = 1'b0;
    endcase
    if (cmd_ok) begin
      flags_nxt[SR_N] = alu_res[WIDTH-1];
      flags_nxt[SR_Z] = (alu_res == '0);
    end
  end

  assign Branch_Taken   = B_IN;
  assign Branch_Address = PC
    + {{(WIDTH-26){Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (S_IN && !freeze) begin
      sr_q <= flags_nxt;
    end
  end

  assign SR = sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      WB_EN      <= 1'b0;
      MEM_R_EN   <= 1'b0;
      MEM_W_EN   <= 1'b0;
      ALU_Result <= '0;
      ST_Val     <= '0;
      Dest       <= '0;
    end else if (!freeze) begin
      WB_EN      <= WB_EN_IN;
      MEM_R_EN   <= MEM_R_EN_IN;
      MEM_W_EN   <= MEM_W_EN_IN;
      ALU_Result <= alu_res;
      ST_Val     <= op2;
      Dest       <= Dest_IN;
    end
  end

endmodule

// File: tb/tb_exe_module.sv
// Self-checking bench for exe_module.
// Scoreboard of expected EXE/MEM contents against a behavioural reference model.
module tb_exe_module;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] st;
    logic [3:0]  dest;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [3:0]  sr;
  } exp_t;

  localparam longint MAXS = 2147483647;
  localparam longint MINS = -MAXS - 1;

  logic        clk = 0;
  logic        rst, freeze;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
  logic [3:0]  exe_cmd;
  logic [31:0] pc, val_rn, val_rm;
  logic        imm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest_in;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] mem_alu_result, wb_value;
  logic [3:0]  sr;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        wb_en, mem_r_en, mem_w_en;
  logic [31:0] alu_result, st_val;
  logic [3:0]  dest;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  exp_t last;
  logic [3:0] msr;

  always #5 clk = ~clk;

  exe_module dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .WB_EN_IN       (wb_en_in),
    .MEM_R_EN_IN    (mem_r_en_in),
    .MEM_W_EN_IN    (mem_w_en_in),
    .B_IN           (b_in),
    .S_IN           (s_in),
    .EXE_CMD        (exe_cmd),
    .PC             (pc),
    .Val_Rn         (val_rn),
    .Val_Rm         (val_rm),
    .imm            (imm),
    .Shift_operand  (shift_operand),
    .Signed_imm_24  (signed_imm_24),
    .Dest_IN        (dest_in),
    .Sel_src1       (sel_src1),
    .Sel_src2       (sel_src2),
    .MEM_ALU_Result (mem_alu_result),
    .WB_Value       (wb_value),
    .SR             (sr),
    .Branch_Taken   (branch_taken),
    .Branch_Address (branch_address),
    .WB_EN          (wb_en),
    .MEM_R_EN       (mem_r_en),
    .MEM_W_EN       (mem_w_en),
    .ALU_Result     (alu_result),
    .ST_Val         (st_val),
    .Dest           (dest)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] m_fwd(input logic [1:0] sel,
      input logic [31:0] rf);
    if (sel == 2'b01) return mem_alu_result;
    if (sel == 2'b10) return wb_value;
    return rf;
  endfunction

  function automatic logic [31:0] m_val2(input logic im, input logic mem,
      input logic [11:0] sh, input logic [31:0] o2);
    logic [31:0] v;
    if (im) begin
      v = {24'b0, sh[7:0]};
      for (int i = 0; i < 2 * sh[11:8]; i++) v = {v[0], v[31:1]};
    end else if (mem) begin
      v = {20'b0, sh};
    end else begin
      v = o2;
      for (int i = 0; i < sh[11:7]; i++) begin
        case (sh[6:5])
          2'b00:   v = {v[30:0], 1'b0};
          2'b01:   v = {1'b0, v[31:1]};
          2'b10:   v = {v[31], v[31:1]};
          default: v = {v[0], v[31:1]};
        endcase
      end
    end
    return v;
  endfunction

  function automatic logic [35:0] m_alu(input logic [3:0] cmd,
      input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    longint la, lb, sa, sb, k, t;
    logic [31:0] r;
    logic c, v, ok;
    la = longint'(a);
    lb = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = s[1]; v = s[0]; ok = 1; r = 0; k = 0;
    case (cmd)
      4'd1: r = b;
      4'd9: r = ~b;
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      4'd2, 4'd3: begin
        k = (cmd == 4'd3 && s[1]) ? 1 : 0;
        t = la + lb + k;
        r = t[31:0];
        c = t > longint'(32'hFFFFFFFF);
        t = sa + sb + k;
        v = (t > MAXS) || (t < MINS);
      end
      4'd4, 4'd5: begin
        k = (cmd == 4'd5 && !s[1]) ? 1 : 0;
        t = la - lb - k;
        r = t[31:0];
        c = la >= lb + k;
        t = sa - sb - k;
        v = (t > MAXS) || (t < MINS);
      end
      default: ok = 0;
    endcase
    if (!ok) return {s, 32'h0};
    return {r[31], r == 32'h0, c, v, r};
  endfunction

  task automatic drive(input logic [3:0] cmd, input logic s,
      input logic im, input logic mr, input logic mw,
      input logic [31:0] rn, input logic [31:0] rm,
      input logic [11:0] sh, input logic [1:0] s1,
      input logic [1:0] s2, input logic [3:0] d);
    exe_cmd = cmd; s_in = s; imm = im;
    mem_r_en_in = mr; mem_w_en_in = mw; wb_en_in = ~mw;
    val_rn = rn; val_rm = rm; shift_operand = sh;
    sel_src1 = s1; sel_src2 = s2; dest_in = d;
  endtask

  task automatic issue(input logic [3:0] cmd, input logic s,
      input logic im, input logic mr, input logic mw,
      input logic [31:0] rn, input logic [31:0] rm,
      input logic [11:0] sh, input logic [1:0] s1,
      input logic [1:0] s2, input logic [3:0] d);
    exp_t e;
    logic [31:0] a, o2, v2;
    logic [35:0] r;
    freeze = 0;
    drive(cmd, s, im, mr, mw, rn, rm, sh, s1, s2, d);
    a  = m_fwd(s1, rn);
    o2 = m_fwd(s2, rm);
    v2 = m_val2(im, mr | mw, sh, o2);
    r  = m_alu(cmd, a, v2, msr);
    if (s) msr = r[35:32];
    e.alu = r[31:0]; e.st = o2; e.dest = d;
    e.wb = ~mw; e.mr = mr; e.mw = mw; e.sr = msr;
    sbq.push_back(e);
    tick();
    e = sbq.pop_front();
    last = e;
    chk("alu", alu_result, e.alu);
    chk("st", st_val, e.st);
    chk("ctl", {24'b0, dest, wb_en, mem_r_en, mem_w_en, 1'b0},
        {24'b0, e.dest, e.wb, e.mr, e.mw, 1'b0});
    chk("sr", {28'b0, sr}, {28'b0, e.sr});
  endtask

  initial begin
    rst = 1; freeze = 0; b_in = 0; pc = 0; signed_imm_24 = 0;
    mem_alu_result = 0; wb_value = 0;
    drive(4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    msr = 0;
    tick(); tick();
    chk("rst_alu", alu_result, 0);
    chk("rst_sr", {28'b0, sr}, 0);
    rst = 0;

    issue(4'd1, 1, 1, 0, 0, 0, 0, 12'h2FF, 0, 0, 4'd1);
    chk("rot_val", alu_result, 32'hF000000F);
    chk("rot_sr", {28'b0, sr}, 32'h8);

    issue(4'd4, 1, 0, 0, 0, 5, 5, 12'h000, 0, 0, 4'd2);
    chk("sub_val", alu_result, 0);
    chk("sub_sr", {28'b0, sr}, 32'h6);
    issue(4'd5, 1, 0, 0, 0, 3, 1, 12'h000, 0, 0, 4'd2);
    chk("sbc_val", alu_result, 2);

    issue(4'd2, 1, 0, 0, 0, 32'h7FFFFFFF, 1, 12'h000, 0, 0, 4'd3);
    chk("ovf_val", alu_result, 32'h80000000);
    chk("ovf_sr", {28'b0, sr}, 32'h9);
    issue(4'd1, 0, 0, 0, 0, 0, 32'h80000000, 12'h240, 0, 0, 4'd3);
    chk("asr_val", alu_result, 32'hF8000000);

    mem_alu_result = 32'h10;
    issue(4'd2, 0, 1, 0, 0, 0, 0, 12'h004, 2'b01, 0, 4'd4);
    chk("fwd_val", alu_result, 32'h14);

    freeze = 1;
    drive(4'd4, 1, 0, 0, 0, 1, 9, 12'h000, 0, 0, 4'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_alu", alu_result, last.alu);
      chk("frz_dst", {28'b0, dest}, {28'b0, last.dest});
      chk("frz_sr", {28'b0, sr}, {28'b0, msr});
    end
    issue(4'd4, 1, 0, 0, 0, 1, 9, 12'h000, 0, 0, 4'd7);

    b_in = 1; pc = 32'h100; signed_imm_24 = 24'hFFFFFE;
    #1;
    chk("br_addr", branch_address, 32'hF8);
    chk("br_taken", {31'b0, branch_taken}, 1);
    b_in = 0; pc = 32'h2000; signed_imm_24 = 24'h000010;
    #1;
    chk("br_addr2", branch_address, 32'h2040);
    chk("br_nt", {31'b0, branch_taken}, 0);

    issue(4'd2, 0, 0, 1, 0, 32'h1000, 32'hDEAD, 12'h804, 0, 0, 4'd5);
    chk("ldr_val", alu_result, 32'h1804);
    wb_value = 32'hCAFEF00D;
    issue(4'd2, 0, 0, 0, 1, 32'h40, 0, 12'h008, 0, 2'b10, 4'd6);
    chk("str_data", st_val, 32'hCAFEF00D);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] rn, rm;
      logic m;
      mem_alu_result = $urandom;
      wb_value = $urandom;
      rn = (n % 7 == 0) ? 32'hFFFFFFFF : $urandom;
      rm = (n % 5 == 0) ? 32'h80000000 : $urandom;
      m  = ($urandom_range(0, 5) == 0);
      issue(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), m, 1'b0, rn, rm,
            12'($urandom), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 4'($urandom));
    end

    issue(4'd2, 1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 12'h000, 0, 0, 4'd8);
    issue(4'd1, 0, 1, 0, 0, 0, 0, 12'h055, 0, 0, 4'd9);
    chk("pre_alu", alu_result, 32'h55);
    chk("pre_sr", {28'b0, sr}, 32'hA);
    rst = 1; freeze = 1;
    drive(4'd2, 1, 0, 0, 0, 7, 7, 12'h000, 0, 0, 4'd3);
    tick();
    chk("mid_rst_alu", alu_result, 0);
    chk("mid_rst_sr", {28'b0, sr}, 0);
    chk("mid_rst_ctl", {24'b0, dest, wb_en, mem_r_en, mem_w_en, 1'b0}, 0);
    chk("mid_rst_st", st_val, 0);
    rst = 0;
    msr = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
